segment_value_sampler: RTL and testbench

- Consumer of the weighted segment chooser's 2-bit segment number.
- Given the chosen segment and per-segment bounds [lower, upper], it draws a uniformly distributed value inside that segment.
- Uses an internal LFSR with power-of-two masking and rejection sampling.
- Sits after the chooser in the MCMC variable-update path. Its output is the proposed new variable value.

---
 rtl/segment_value_sampler.sv | 182 ++++++++++++++++++
 tb/tb_segment_value_sampler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_value_sampler.sv
// Draws a uniformly distributed value inside a chosen segment [lower, upper] using
// an 8-bit LFSR with power-of-two masking and rejection. Optional: SAMPLER_STATS_EN.
module segment_value_sampler #(
  parameter int VALUE_WIDTH = 8,
  parameter int MAX_TRIES   = 16
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic                   in_seed_load,
  input  logic [7:0]             in_seed,
  input  logic                   in_start,
  input  logic [1:0]             in_segment_number,
  input  logic [VALUE_WIDTH-1:0] in_lower0,
  input  logic [VALUE_WIDTH-1:0] in_lower1,
  input  logic [VALUE_WIDTH-1:0] in_lower2,
  input  logic [VALUE_WIDTH-1:0] in_lower3,
  input  logic [VALUE_WIDTH-1:0] in_upper0,
  input  logic [VALUE_WIDTH-1:0] in_upper1,
  input  logic [VALUE_WIDTH-1:0] in_upper2,
  input  logic [VALUE_WIDTH-1:0] in_upper3,
`ifdef SAMPLER_STATS_EN
  output logic [15:0]            out_reject_count,
`endif
  output logic                   out_busy,
  output logic                   out_valid,
  output logic [VALUE_WIDTH-1:0] out_value,
  output logic                   out_fallback,
  output logic                   out_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             lfsr_q;
  logic [7:0]             try_cnt_q;
  logic [VALUE_WIDTH-1:0] lower_q, upper_q;
  logic [VALUE_WIDTH-1:0] span_q, mask_q;
  logic [VALUE_WIDTH-1:0] result_q;
  logic                   fallback_q, error_q;

  logic [VALUE_WIDTH-1:0] sel_lower, sel_upper;
  logic [VALUE_WIDTH-1:0] rand_word, draw_r;
  logic                   draw_hit, last_try, bad_bounds;

  // Smallest 2^k-1 covering v: smear the highest set bit downwards.
  function automatic logic [VALUE_WIDTH-1:0] fill_mask(input logic [VALUE_WIDTH-1:0] v);
    logic [VALUE_WIDTH-1:0] m;
    m = v;
    for (int i = 1; i < VALUE_WIDTH; i++) m = m | (v >> i);
    return m;
  endfunction

  always_comb begin
    sel_lower = in_lower0;
    sel_upper = in_upper0;
    case (in_segment_number)
      2'd1: begin sel_lower = in_lower1; sel_upper = in_upper1; end
      2'd2: begin sel_lower = in_lower2; sel_upper = in_upper2; end
      2'd3: begin sel_lower = in_lower3; sel_upper = in_upper3; end
      default: ;
    endcase
  end

  // The 8-bit LFSR state is repeated across the draw word so any VALUE_WIDTH works.
  always_comb begin
    rand_word = '0;
    for (int i = 0; i < VALUE_WIDTH; i++) rand_word[i] = lfsr_q[i % 8];
  end

  assign draw_r     = rand_word & mask_q;
  assign draw_hit   = (draw_r <= span_q);
  assign last_try   = (try_cnt_q == 8'(MAX_TRIES - 1));
  assign bad_bounds = (lower_q > upper_q);
  assign out_busy   = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_start) state_d = S_LOAD;
      S_LOAD: state_d = bad_bounds ? S_DONE : S_DRAW;
      S_DRAW: if (draw_hit || last_try) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1; a seed load wins over the draw shift.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      lfsr_q <= 8'h01;
    end else if (in_seed_load) begin
      lfsr_q <= (in_seed == 8'h00) ? 8'h01 : in_seed;
    end else if (state_q == S_DRAW) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      try_cnt_q    <= '0;
      lower_q      <= '0;
      upper_q      <= '0;
      span_q       <= '0;
      mask_q       <= '0;
      result_q     <= '0;
      fallback_q   <= 1'b0;
      error_q      <= 1'b0;
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_fallback <= 1'b0;
      out_error    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (in_start) begin
            lower_q      <= sel_lower;
            upper_q      <= sel_upper;
            fallback_q   <= 1'b0;
            error_q      <= 1'b0;
            try_cnt_q    <= '0;
            out_fallback <= 1'b0;
            out_error    <= 1'b0;
          end
        end
        S_LOAD: begin
          span_q <= upper_q - lower_q;
          mask_q <= fill_mask(upper_q - lower_q);
          if (bad_bounds) begin
            result_q <= lower_q;
            error_q  <= 1'b1;
          end
        end
        S_DRAW: begin
          if (draw_hit) begin
            result_q <= lower_q + draw_r;
          end else begin
            try_cnt_q <= try_cnt_q + 8'd1;
            if (last_try) begin
              result_q   <= lower_q;
              fallback_q <= 1'b1;
            end
          end
        end
        S_DONE: begin
          // Result and flags appear together with the valid pulse.
          out_valid    <= 1'b1;
          out_value    <= result_q;
          out_fallback <= fallback_q;
          out_error    <= error_q;
          try_cnt_q    <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef SAMPLER_STATS_EN
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      out_reject_count <= '0;
    end else if (state_q == S_DRAW && !draw_hit && out_reject_count != 16'hFFFF) begin
      out_reject_count <= out_reject_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_segment_value_sampler.sv
// Scoreboard bench for segment_value_sampler: a sampling model predicts value, flags
// and start-to-valid latency; a negedge monitor compares each out_valid pulse.
module tb_segment_value_sampler;

  localparam int VW        = 8;
  localparam int MAX_TRIES = 16;

  typedef struct {
    logic [7:0] value;
    logic       fb;
    logic       err;
    int         accept_cyc;
    int         latency;
  } exp_t;

  logic          in_clock = 1'b0;
  logic          in_reset = 1'b0;
  logic          in_seed_load = 1'b0;
  logic [7:0]    in_seed = '0;
  logic          in_start = 1'b0;
  logic [1:0]    in_segment_number = '0;
  logic [VW-1:0] lower_b [4];
  logic [VW-1:0] upper_b [4];
  logic          out_busy, out_valid, out_fallback, out_error;
  logic [VW-1:0] out_value;

  segment_value_sampler #(.VALUE_WIDTH(VW), .MAX_TRIES(MAX_TRIES)) dut (
    .in_clock(in_clock), .in_reset(in_reset),
    .in_seed_load(in_seed_load), .in_seed(in_seed),
    .in_start(in_start), .in_segment_number(in_segment_number),
    .in_lower0(lower_b[0]), .in_lower1(lower_b[1]),
    .in_lower2(lower_b[2]), .in_lower3(lower_b[3]),
    .in_upper0(upper_b[0]), .in_upper1(upper_b[1]),
    .in_upper2(upper_b[2]), .in_upper3(upper_b[3]),
    .out_busy(out_busy), .out_valid(out_valid), .out_value(out_value),
    .out_fallback(out_fallback), .out_error(out_error)
  );

  initial forever #5 in_clock = ~in_clock;

  int         checks = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] m_lfsr = 8'h01;
  exp_t       sb_q [$];

  // Monitor statistics
  bit           track_en = 0;
  int           trk_lo = 0, trk_hi = 255;
  bit [255:0]   seen = '0;
  int           max_lat = 0;
  int           rej_samples = 0;
  bit           rec_en = 0;
  logic [7:0]   rec_q [$];
  exp_t         mon_e;
  int           mon_lat;

  always @(posedge in_clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  // Reference: mask is the smallest 2^k-1 >= span; draw until r <= span or tries run out.
  task automatic model_sample(input logic [7:0] lo, input logic [7:0] hi, output exp_t e);
    int span, mask, r;
    e.value = lo; e.fb = 1'b0; e.err = 1'b0; e.accept_cyc = 0;
    if (lo > hi) begin
      e.err = 1'b1;
      e.latency = 2;
      return;
    end
    span = int'(hi) - int'(lo);
    mask = 0;
    while (mask < span) mask = mask * 2 + 1;
    for (int t = 1; t <= MAX_TRIES; t++) begin
      r = int'(m_lfsr) & mask;
      m_lfsr = lfsr_next(m_lfsr);
      if (r <= span) begin
        e.value = 8'(int'(lo) + r);
        e.latency = 2 + t;
        return;
      end
    end
    e.fb = 1'b1;
    e.latency = 2 + MAX_TRIES;
  endtask

  always @(negedge in_clock) begin
    if (!in_reset && out_valid) begin
      if (sb_q.size() == 0) begin
        check("spurious_valid", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        mon_lat = cyc - mon_e.accept_cyc;
        check("value", 32'(out_value), 32'(mon_e.value));
        check("fallback", 32'(out_fallback), 32'(mon_e.fb));
        check("error", 32'(out_error), 32'(mon_e.err));
        check("latency", 32'(mon_lat), 32'(mon_e.latency));
        if (track_en) begin
          seen[out_value] = 1'b1;
          if (mon_lat > max_lat) max_lat = mon_lat;
          if (mon_lat > 3) rej_samples++;
          check("in_range", 32'(int'(out_value) >= trk_lo && int'(out_value) <= trk_hi), 32'd1);
        end
        if (rec_en) rec_q.push_back(out_value);
      end
    end
  end

  // One clock of stimulus; a start seen while idle is pushed to the scoreboard.
  task automatic step(input logic start, input logic [1:0] seg, output bit pushed);
    exp_t e;
    @(negedge in_clock);
    in_start = start;
    in_segment_number = seg;
    in_seed_load = 1'b0;
    pushed = 0;
    if (start && !out_busy && !in_reset) begin
      model_sample(lower_b[seg], upper_b[seg], e);
      e.accept_cyc = cyc + 1;
      sb_q.push_back(e);
      pushed = 1;
    end
    @(posedge in_clock);
    #1;
  endtask

  task automatic drain();
    bit p;
    int n = 0;
    while ((sb_q.size() != 0 || out_busy || out_valid) && n < 400) begin
      step(1'b0, in_segment_number, p);
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic seed_load(input logic [7:0] s);
    @(negedge in_clock);
    in_start = 1'b0;
    in_seed_load = 1'b1;
    in_seed = s;
    m_lfsr = (s == 8'h00) ? 8'h01 : s;
    @(posedge in_clock);
    #1;
    in_seed_load = 1'b0;
  endtask

  task automatic run_held(input logic [1:0] seg, input int n);
    bit p;
    int got = 0;
    for (int i = 0; i < n * 40 && got < n; i++) begin
      step(1'b1, seg, p);
      if (p) got++;
    end
    check("held_accepts", 32'(got), 32'(n));
    drain();
  endtask

  task automatic reset_stats(input int lo, input int hi);
    seen = '0; max_lat = 0; rej_samples = 0; trk_lo = lo; trk_hi = hi;
  endtask

  function automatic int count_seen();
    int c = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) c++;
    return c;
  endfunction

  logic [7:0] rec1 [$];
  int         seg_seq [20];

  initial begin
    bit p;
    for (int s = 0; s < 4; s++) begin lower_b[s] = '0; upper_b[s] = '0; end
    in_reset = 1'b1;
    #1;
    check("rst_busy", 32'(out_busy), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_value", 32'(out_value), 32'd0);
    check("rst_fallback", 32'(out_fallback), 32'd0);
    check("rst_error", 32'(out_error), 32'd0);
    repeat (3) @(negedge in_clock);
    in_reset = 1'b0;

    // Span 0: value 5 with the 3-cycle minimum latency
    lower_b[2] = 8'd5; upper_b[2] = 8'd5;
    step(1'b1, 2'd2, p);
    drain();

    // Span 7, mask 7: one draw per sample, all eight values appear
    lower_b[1] = 8'd10; upper_b[1] = 8'd17;
    seed_load(8'h01);
    reset_stats(10, 17); track_en = 1;
    run_held(2'd1, 1000);
    track_en = 0;
    check("seg1_all_values", 32'(count_seen()), 32'd8);
    check("seg1_one_draw", 32'(max_lat), 32'd3);

    // Span 8, mask 15: rejections happen but never exceed MAX_TRIES draws
    lower_b[0] = 8'd0; upper_b[0] = 8'd8;
    reset_stats(0, 8); track_en = 1;
    run_held(2'd0, 1000);
    track_en = 0;
    check("seg0_rejections", 32'(rej_samples > 0), 32'd1);
    check("seg0_max_draws", 32'(max_lat <= 2 + MAX_TRIES), 32'd1);

    // Inverted bounds flag an error, cleared by the next accepted start
    lower_b[3] = 8'd20; upper_b[3] = 8'd3;
    step(1'b1, 2'd3, p);
    drain();
    check("err_held", 32'(out_error), 32'd1);
    step(1'b1, 2'd2, p);
    check("err_cleared", 32'(out_error), 32'd0);
    drain();

    // Held start with the segment changing while busy
    for (int i = 0; i < 120; i++) step(1'b1, 2'(i % 3), p);
    drain();

    // Reset while in DRAW
    lower_b[0] = 8'd0; upper_b[0] = 8'd200;
    step(1'b1, 2'd0, p);
    step(1'b0, 2'd0, p);
    step(1'b0, 2'd0, p);
    check("pre_reset_busy", 32'(out_busy), 32'd1);
    in_reset = 1'b1;
    #1;
    check("mid_rst_busy", 32'(out_busy), 32'd0);
    check("mid_rst_value", 32'(out_value), 32'd0);
    check("mid_rst_error", 32'(out_error), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    m_lfsr = 8'h01;
    @(negedge in_clock);
    in_reset = 1'b0;
    step(1'b1, 2'd0, p);
    step(1'b1, 2'd1, p);
    drain();

    // Same seed and start sequence give the same stream
    for (int s = 0; s < 4; s++) begin
      lower_b[s] = 8'($urandom_range(0, 120));
      upper_b[s] = lower_b[s] + 8'($urandom_range(0, 130));
    end
    for (int i = 0; i < 20; i++) seg_seq[i] = $urandom_range(0, 3);
    for (int pass = 0; pass < 2; pass++) begin
      seed_load(8'h5A);
      rec_q.delete();
      rec_en = 1;
      for (int i = 0; i < 20; i++) begin
        step(1'b1, 2'(seg_seq[i]), p);
        drain();
      end
      rec_en = 0;
      if (pass == 0) rec1 = rec_q;
    end
    check("det_len", 32'(rec_q.size()), 32'(rec1.size()));
    for (int i = 0; i < rec1.size() && i < rec_q.size(); i++)
      check("det_stream", 32'(rec_q[i]), 32'(rec1[i]));

    // Randomized traffic, occasional reseeds (including seed 0)
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int s = 0; s < 4; s++) begin
          lower_b[s] = 8'($urandom);
          if ($urandom_range(0, 4) == 0) upper_b[s] = 8'($urandom);
          else upper_b[s] = lower_b[s] + 8'($urandom_range(0, 255 - int'(lower_b[s])));
        end
      end
      if (i % 150 == 75) begin
        drain();
        seed_load(($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom));
      end
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), p);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
